// File: rtl/dcache.sv
// Direct-mapped, write-back, write-allocate data cache with a line-wide memory port.
// Define DCACHE_STATS_EN to add the hit_count/miss_count statistics outputs.
module dcache #(
   parameter int LINES       = 16,
   parameter int WIDTH       = 16,
   parameter int MEM_LATENCY = 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [31:0]        addr,
   input  logic [31:0]        wdata,
   input  logic               read,
   input  logic               write,
   output logic [31:0]        rdata,
   output logic               stall,
   output logic [31:0]        mem_addr,
   output logic [WIDTH*8-1:0] mem_wdata,
   output logic               mem_read,
   output logic               mem_write,
`ifdef DCACHE_STATS_EN
   output logic [31:0]        hit_count,
   output logic [31:0]        miss_count,
`endif
   input  logic [WIDTH*8-1:0] mem_rdata
);

   localparam int OFF_W  = $clog2(WIDTH);
   localparam int IDX_W  = $clog2(LINES);
   localparam int TAG_W  = 32 - OFF_W - IDX_W;
   localparam int WORDS  = WIDTH / 4;
   localparam int WSEL_W = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam int CNT_W  = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
   localparam int LINE_W = WIDTH * 8;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY - 1);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WRITEBACK = 2'd1,
      FILL      = 2'd2,
      FILL_WAIT = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               reset_q;
   logic [LINES-1:0]   valid_q;
   logic [LINES-1:0]   dirty_q;
   logic [TAG_W-1:0]   tag_q  [LINES];
   logic [LINE_W-1:0]  data_q [LINES];

   logic [IDX_W-1:0]   idx_s;
   logic [TAG_W-1:0]   tag_s;
   logic [WSEL_W-1:0]  wsel_s;
   logic [TAG_W-1:0]   vtag_s;
   logic [LINE_W-1:0]  line_s;
   logic [LINE_W-1:0]  wr_line_s;
   logic [31:0]        rd_word_s;
   logic               hit_s;
   logic               req_s;
   logic               quiet_s;
   logic               line_we_s;
   logic               fill_s;
   logic               unused_s;

   assign idx_s    = addr[OFF_W +: IDX_W];
   assign tag_s    = addr[31 -: TAG_W];
   assign unused_s = ^addr[1:0];

   generate
      if (WORDS > 1) begin : g_wsel
         assign wsel_s = addr[OFF_W-1:2];
      end else begin : g_wsel_one
         assign wsel_s = 1'b0;
      end
   endgenerate

   assign line_s  = data_q[idx_s];
   assign vtag_s  = tag_q[idx_s];
   assign hit_s   = valid_q[idx_s] && (vtag_s == tag_s);
   // The cycle of reset and the one after it must stay silent, so requests are masked there.
   assign quiet_s = reset | reset_q;
   assign req_s   = (read | write) & ~quiet_s;

   // Word extraction for loads and word merge for stores.
   always_comb begin
      rd_word_s = line_s[32*wsel_s +: 32];
      wr_line_s = line_s;
      wr_line_s[32*wsel_s +: 32] = wdata;
   end

   // Next-state and output decode for the miss-handling FSM.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      stall     = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      mem_addr  = 32'h0;
      mem_wdata = '0;
      rdata     = 32'h0;
      line_we_s = 1'b0;
      fill_s    = 1'b0;
      if (!quiet_s) begin
         case (state_q)
            IDLE: begin
               if (req_s) begin
                  if (hit_s) begin
                     if (read) rdata = rd_word_s;
                     else      rdata = 32'h0;
                     if (write) line_we_s = 1'b1;
                     else       line_we_s = 1'b0;
                  end else begin
                     stall = 1'b1;
                     if (valid_q[idx_s] && dirty_q[idx_s]) state_d = WRITEBACK;
                     else                                  state_d = FILL;
                  end
               end else begin
                  state_d = IDLE;
               end
            end
            WRITEBACK: begin
               stall     = 1'b1;
               mem_write = 1'b1;
               mem_addr  = {vtag_s, idx_s, {OFF_W{1'b0}}};
               mem_wdata = line_s;
               state_d   = FILL;
            end
            FILL: begin
               stall    = 1'b1;
               mem_read = 1'b1;
               mem_addr = {tag_s, idx_s, {OFF_W{1'b0}}};
               cnt_d    = '0;
               state_d  = FILL_WAIT;
            end
            FILL_WAIT: begin
               stall = 1'b1;
               if (cnt_q == CNT_LAST) begin
                  fill_s  = 1'b1;
                  cnt_d   = '0;
                  state_d = IDLE;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         endcase
      end else begin
         state_d = IDLE;
         cnt_d   = '0;
      end
   end

   // FSM state, wait counter and per-line status bits.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         reset_q <= 1'b1;
         valid_q <= '0;
         dirty_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         reset_q <= 1'b0;
         if (fill_s) begin
            valid_q[idx_s] <= 1'b1;
            dirty_q[idx_s] <= 1'b0;
         end else if (line_we_s) begin
            dirty_q[idx_s] <= 1'b1;
         end
      end
   end

   // Data and tag arrays are left uninitialised; valid bits guard them.
   always_ff @(posedge clk) begin
      if (fill_s) begin
         data_q[idx_s] <= mem_rdata;
         tag_q[idx_s]  <= tag_s;
      end else if (line_we_s) begin
         data_q[idx_s] <= wr_line_s;
      end
   end

`ifdef DCACHE_STATS_EN
   logic [31:0] hit_count_q;
   logic [31:0] miss_count_q;
   logic        after_fill_q;

   // The hit that completes a refilled request is not a first-cycle hit.
   always_ff @(posedge clk) begin
      if (reset) begin
         hit_count_q  <= 32'h0;
         miss_count_q <= 32'h0;
         after_fill_q <= 1'b0;
      end else begin
         after_fill_q <= fill_s;
         if ((state_q == IDLE) && req_s && hit_s && !after_fill_q)
            hit_count_q <= hit_count_q + 32'd1;
         if ((state_q == IDLE) && req_s && !hit_s)
            miss_count_q <= miss_count_q + 32'd1;
      end
   end

   assign hit_count  = hit_count_q;
   assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_dcache.sv
// Scoreboard bench for dcache: instance 0 uses MEM_LATENCY=1, instance 1 uses MEM_LATENCY=3.
module tb_dcache;

   localparam logic [127:0] GARBAGE = 128'hBAD0BAD0_BAD1BAD1_BAD2BAD2_BAD3BAD3;

   typedef struct {
      int          id;
      logic [31:0] rdata;
      int          stalls;
      string       name;
   } done_t;

   typedef struct {
      int           id;
      bit           wr;
      logic [31:0]  addr;
      logic [127:0] data;
   } memtx_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             reset;
   logic [1:0][31:0] addr_s;
   logic [1:0][31:0] wdata_s;
   logic [1:0]       read_s;
   logic [1:0]       write_s;
   logic [127:0]     mem_rdata_s [2];

   logic [31:0]  rdata0, rdata1, mem_addr0, mem_addr1;
   logic         stall0, stall1, mem_read0, mem_read1, mem_write0, mem_write1;
   logic [127:0] mem_wdata0, mem_wdata1;
`ifdef DCACHE_STATS_EN
   logic [31:0]  hc0, mc0, hc1, mc1;
`endif

   logic [1:0][31:0]  rdata_v, mem_addr_v;
   logic [1:0]        stall_v, mem_read_v, mem_write_v;
   logic [1:0][127:0] mem_wdata_v;
   assign rdata_v     = {rdata1, rdata0};
   assign mem_addr_v  = {mem_addr1, mem_addr0};
   assign stall_v     = {stall1, stall0};
   assign mem_read_v  = {mem_read1, mem_read0};
   assign mem_write_v = {mem_write1, mem_write0};
   assign mem_wdata_v = {mem_wdata1, mem_wdata0};

   dcache #(.LINES(16), .WIDTH(16), .MEM_LATENCY(1)) u_dut0 (
      .clk(clk), .reset(reset), .addr(addr_s[0]), .wdata(wdata_s[0]),
      .read(read_s[0]), .write(write_s[0]), .rdata(rdata0), .stall(stall0),
      .mem_addr(mem_addr0), .mem_wdata(mem_wdata0), .mem_read(mem_read0),
      .mem_write(mem_write0),
`ifdef DCACHE_STATS_EN
      .hit_count(hc0), .miss_count(mc0),
`endif
      .mem_rdata(mem_rdata_s[0])
   );

   dcache #(.LINES(16), .WIDTH(16), .MEM_LATENCY(3)) u_dut1 (
      .clk(clk), .reset(reset), .addr(addr_s[1]), .wdata(wdata_s[1]),
      .read(read_s[1]), .write(write_s[1]), .rdata(rdata1), .stall(stall1),
      .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_read(mem_read1),
      .mem_write(mem_write1),
`ifdef DCACHE_STATS_EN
      .hit_count(hc1), .miss_count(mc1),
`endif
      .mem_rdata(mem_rdata_s[1])
   );

   int checks = 0;
   int errors = 0;
   done_t  done_q[$];
   memtx_t mem_q[$];
   logic [127:0] mem_m [logic [63:0]];
   int stall_cnt [2];

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [127:0] line_get(input int id, input logic [31:0] a);
      logic [63:0]  k;
      logic [127:0] l;
      k = {32'(id), a};
      if (mem_m.exists(k)) return mem_m[k];
      for (int w = 0; w < 4; w++) l[32*w +: 32] = 32'h1000_0000 | (a + 32'(4*w));
      return l;
   endfunction

   // Memory model: answers a fill exactly LAT cycles after mem_read, garbage otherwise.
   int          mcnt [2] = '{-1, -1};
   logic [31:0] mpa  [2];
   always begin
      @(negedge clk);
      for (int i = 0; i < 2; i++)
         if (mem_read_v[i]) begin
            mcnt[i] = (i == 0) ? 1 : 3;
            mpa[i]  = mem_addr_v[i];
         end
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         if (mcnt[i] > 0) mcnt[i]--;
         if (mcnt[i] == 0) begin
            mem_rdata_s[i] = line_get(i, mpa[i]);
            mcnt[i] = -1;
         end else begin
            mem_rdata_s[i] = GARBAGE;
         end
      end
   end

   // Monitor: pops the scoreboard on every completed request and every memory strobe.
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (!reset && (read_s[i] || write_s[i])) begin
            if (stall_v[i]) stall_cnt[i]++;
            else if (done_q.size() == 0) chk("unexpected_completion", 128'(i), 128'hFF);
            else begin
               done_t e;
               e = done_q.pop_front();
               chk({e.name, "_inst"}, 128'(i), 128'(e.id));
               chk({e.name, "_rdata"}, 128'(rdata_v[i]), 128'(e.rdata));
               chk({e.name, "_stalls"}, 128'(stall_cnt[i]), 128'(e.stalls));
               stall_cnt[i] = 0;
            end
         end else begin
            stall_cnt[i] = 0;
         end
         if (mem_read_v[i] || mem_write_v[i]) begin
            chk("strobe_exclusive", 128'(mem_read_v[i] & mem_write_v[i]), 128'h0);
            if (mem_q.size() == 0) chk("unexpected_strobe", 128'(mem_addr_v[i]), 128'hFFFF_FFFF);
            else begin
               memtx_t m;
               m = mem_q.pop_front();
               chk("mem_inst", 128'(i), 128'(m.id));
               chk("mem_is_write", 128'(mem_write_v[i]), 128'(m.wr));
               chk("mem_addr", 128'(mem_addr_v[i]), 128'(m.addr));
               if (m.wr) chk("mem_wdata", mem_wdata_v[i], m.data);
            end
            if (mem_write_v[i]) mem_m[{32'(i), mem_addr_v[i]}] = mem_wdata_v[i];
         end
      end
   end

   task automatic exp_mem(input int id, input bit wr, input logic [31:0] a, input logic [127:0] d);
      memtx_t m;
      m.id = id; m.wr = wr; m.addr = a; m.data = d;
      mem_q.push_back(m);
   endtask

   task automatic do_req(input int id, input bit rd, input bit wr, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] exp_rd, input int exp_st,
                         input string nm);
      done_t e;
      bit    fin;
      e.id = id; e.rdata = exp_rd; e.stalls = exp_st; e.name = nm;
      done_q.push_back(e);
      fin = 1'b0;
      @(posedge clk); #2;
      addr_s[id] = a; wdata_s[id] = wd; read_s[id] = rd; write_s[id] = wr;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (!stall_v[id]) begin
            fin = 1'b1;
            break;
         end
      end
      if (!fin) chk({nm, "_timeout"}, 128'h1, 128'h0);
      @(posedge clk); #2;
      read_s[id] = 1'b0; write_s[id] = 1'b0;
   endtask

   task automatic chk_quiet(input int i, input string nm);
      chk({nm, "_stall"}, 128'(stall_v[i]), 128'h0);
      chk({nm, "_mem_read"}, 128'(mem_read_v[i]), 128'h0);
      chk({nm, "_mem_write"}, 128'(mem_write_v[i]), 128'h0);
      chk({nm, "_rdata"}, 128'(rdata_v[i]), 128'h0);
   endtask

   initial begin
      reset = 1'b1;
      addr_s = '0; wdata_s = '0; read_s = '0; write_s = '0;
      mem_rdata_s[0] = GARBAGE; mem_rdata_s[1] = GARBAGE;
      mem_m[{32'd0, 32'h100}] = 128'h00000044_00000033_00000022_00000011;
      mem_m[{32'd0, 32'h200}] = 128'h000000A3_000000A2_000000A1_000000A0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_quiet(0, "in_reset0");
      chk_quiet(1, "in_reset1");
      @(posedge clk); #2;
      reset = 1'b0;
      @(negedge clk);
      chk_quiet(0, "after_reset0");
      chk_quiet(1, "after_reset1");
      @(negedge clk);
      chk_quiet(0, "idle0");

      // Instance 0, MEM_LATENCY=1
      exp_mem(0, 1'b0, 32'h100, '0);
      do_req(0, 1'b1, 1'b0, 32'h100, 32'h0, 32'h11, 3, "clean_miss_100");
      do_req(0, 1'b0, 1'b1, 32'h104, 32'hDEADBEEF, 32'h0, 0, "store_hit_104");
      do_req(0, 1'b1, 1'b0, 32'h104, 32'h0, 32'hDEADBEEF, 0, "load_hit_104");
      exp_mem(0, 1'b1, 32'h100, 128'h00000044_00000033_DEADBEEF_00000011);
      exp_mem(0, 1'b0, 32'h200, '0);
      do_req(0, 1'b1, 1'b0, 32'h200, 32'h0, 32'hA0, 4, "dirty_miss_200");
      do_req(0, 1'b1, 1'b1, 32'h208, 32'h12345678, 32'hA2, 0, "rw_store_208");
      do_req(0, 1'b1, 1'b0, 32'h208, 32'h0, 32'h12345678, 0, "load_hit_208");
      exp_mem(0, 1'b1, 32'h200, 128'h000000A3_12345678_000000A1_000000A0);
      exp_mem(0, 1'b0, 32'h100, '0);
      do_req(0, 1'b1, 1'b0, 32'h104, 32'h0, 32'hDEADBEEF, 4, "refetch_104");
      exp_mem(0, 1'b0, 32'h110, '0);
      do_req(0, 1'b1, 1'b0, 32'h114, 32'h0, 32'h10000114, 3, "miss_idx1");
      exp_mem(0, 1'b0, 32'h1F0, '0);
      do_req(0, 1'b1, 1'b0, 32'h1FC, 32'h0, 32'h100001FC, 3, "miss_idx15");
      do_req(0, 1'b0, 1'b1, 32'h1F8, 32'hCAFEF00D, 32'h0, 0, "store_idx15");
      do_req(0, 1'b1, 1'b0, 32'h1F8, 32'h0, 32'hCAFEF00D, 0, "load_idx15");

      // Instance 1, MEM_LATENCY=3
      exp_mem(1, 1'b0, 32'h300, '0);
      do_req(1, 1'b1, 1'b0, 32'h300, 32'h0, 32'h10000300, 5, "lat3_miss_300");
      do_req(1, 1'b1, 1'b0, 32'h304, 32'h0, 32'h10000304, 0, "lat3_hit_304");

      // Reset during FILL_WAIT abandons the miss.
      exp_mem(1, 1'b0, 32'h400, '0);
      @(posedge clk); #2;
      addr_s[1] = 32'h400; read_s[1] = 1'b1;
      @(posedge clk); #2;
      @(posedge clk); #2;
      reset = 1'b1; read_s[1] = 1'b0;
      @(negedge clk);
      chk_quiet(1, "abort_in_reset");
      @(posedge clk); #2;
      reset = 1'b0;
      @(negedge clk);
      chk_quiet(1, "abort_after_reset");
      exp_mem(1, 1'b0, 32'h400, '0);
      do_req(1, 1'b1, 1'b0, 32'h400, 32'h0, 32'h10000400, 5, "reissue_400");

      repeat (6) @(posedge clk);
      chk("done_queue_empty", 128'(done_q.size()), 128'h0);
      chk("mem_queue_empty", 128'(mem_q.size()), 128'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule
